// File: rtl/tdm_demux4_if.sv
// Parallel side of the 4-channel TDM receiver: serial sample in, four channel words,
// slot index and frame/error pulses out.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       select;
  logic             out_valid;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_start,
    input  a, b, c, d, select, out_valid, sync_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output a, b, c, d, select, out_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: collects slots a..c in shadow registers and commits the whole
// frame to the channel outputs when slot d arrives; early frame markers raise sync_err.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input logic          clk,
  input logic          reset,
  tdm_demux4_if.slave  bus
);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [1:0]       select_reg;
  logic [WIDTH-1:0] shadow_reg [0:2];
  logic [WIDTH-1:0] a_reg, b_reg, c_reg, d_reg;
  logic             out_valid_reg;
  logic             sync_err_reg;

  logic       restart;
  logic       early;
  logic       store;
  logic       complete;
  logic [2:0] shadow_we;

  // A qualified marker always starts a fresh frame, whatever state we are in.
  assign restart  = bus.din_valid && bus.frame_start;
  assign early    = restart && (state_reg == RUN) && (select_reg != 2'd0);
  assign store    = bus.din_valid && !bus.frame_start && (state_reg == RUN);
  assign complete = store && (select_reg == 2'd3);

  always_comb begin
    shadow_we = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (restart)
        shadow_we[i] = (i == 0);
      else
        shadow_we[i] = store && (select_reg == 2'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++)
        shadow_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (shadow_we[i])
          shadow_reg[i] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= HUNT;
      select_reg    <= 2'd0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      sync_err_reg  <= early;
      if (restart) begin
        state_reg  <= RUN;
        select_reg <= 2'd1;
      end else if (complete) begin
        // Slot d goes straight from din so all four channels update on this edge.
        a_reg         <= shadow_reg[0];
        b_reg         <= shadow_reg[1];
        c_reg         <= shadow_reg[2];
        d_reg         <= bus.din;
        out_valid_reg <= 1'b1;
        select_reg    <= 2'd0;
        state_reg     <= HUNT;
      end else if (store) begin
        select_reg <= select_reg + 2'd1;
      end
    end
  end

  assign bus.a         = a_reg;
  assign bus.b         = b_reg;
  assign bus.c         = c_reg;
  assign bus.d         = d_reg;
  assign bus.select    = select_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sync_err  = sync_err_reg;
endmodule
